// File: rtl/shake_block_assembler_if.sv
// Stream bundle around the SHAKE256 block assembler: 64-bit message words in, rate-sized blocks out.
// The assembler takes the slave view; whatever feeds words and drains blocks takes the master view.
interface shake_block_assembler_if #(
    parameter int W    = 64,
    parameter int RATE = 1088
);
    logic [W-1:0]    s_data;
    logic            s_valid;
    logic            s_ready;
    logic            s_last;
    logic [6:0]      s_bits;
    logic [RATE-1:0] blk_data;
    logic [10:0]     blk_len;
    logic            blk_last;
    logic            blk_valid;
    logic            blk_ready;

    modport slave (
        input  s_data, s_valid, s_last, s_bits, blk_ready,
        output s_ready, blk_data, blk_len, blk_last, blk_valid
    );

    modport master (
        output s_data, s_valid, s_last, s_bits, blk_ready,
        input  s_ready, blk_data, blk_len, blk_last, blk_valid
    );
endinterface

// File: rtl/shake_block_assembler.sv
// Packs a stream of 64-bit message words MSB-first into 1088-bit rate blocks, tagging each
// block with its valid-bit length and whether it closes the message.
module shake_block_assembler #(
    parameter int RATE  = 1088,
    parameter int W     = 64,
    parameter int WORDS = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    shake_block_assembler_if.slave  bus
);
    localparam int KW     = $clog2(WORDS);
    localparam int LEN_W  = 11;
    localparam int BITS_W = 7;

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t            state;
    logic [KW-1:0]     k;
    logic [RATE-1:0]   buffer;
    logic [LEN_W-1:0]  len_q;
    logic              last_q;
    logic              valid_q;
    logic              ready_q;

    logic [BITS_W-1:0] eff;
    logic [W-1:0]      masked;
    logic [RATE-1:0]   buffer_fill;
    logic [LEN_W-1:0]  len_next;
    logic              accept;
    logic              closes_block;

    // Oversized s_bits on a last word clamp to a full word; non-last words are always full.
    always_comb begin
        eff = BITS_W'(W);
        if (bus.s_last && (bus.s_bits < BITS_W'(W))) begin
            eff = bus.s_bits;
        end
    end

    always_comb begin
        masked = bus.s_data;
        if (eff < BITS_W'(W)) begin
            masked = bus.s_data & ~({W{1'b1}} >> eff);
        end
    end

    // Unrolled slot select keeps every buffer slice at a constant position.
    always_comb begin
        buffer_fill = buffer;
        for (int i = 0; i < WORDS; i++) begin
            if (k == KW'(i)) begin
                buffer_fill[RATE-1-W*i -: W] = masked;
            end
        end
    end

    assign len_next     = LEN_W'(W) * LEN_W'(k) + LEN_W'(eff);
    assign accept       = bus.s_valid && ready_q;
    assign closes_block = bus.s_last || (k == KW'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            k       <= '0;
            buffer  <= '0;
            len_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        buffer <= buffer_fill;
                        if (closes_block) begin
                            state   <= HOLD;
                            k       <= '0;
                            len_q   <= len_next;
                            last_q  <= bus.s_last;
                            valid_q <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                // Clearing on release means the next message always starts from a zero block.
                HOLD: begin
                    if (bus.blk_ready) begin
                        state   <= FILL;
                        buffer  <= '0;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    assign bus.s_ready   = ready_q & ~rst;
    assign bus.blk_data  = buffer;
    assign bus.blk_len   = len_q;
    assign bus.blk_last  = last_q;
    assign bus.blk_valid = valid_q;
endmodule

// File: tb/tb_shake_block_assembler.sv
// Directed bench for shake_block_assembler: drives words on the falling edge and checks
// blocks against hand-built expectations.
module tb_shake_block_assembler;
    localparam int W     = 64;
    localparam int RATE  = 1088;
    localparam int WORDS = 17;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    shake_block_assembler_if #(.W(W), .RATE(RATE)) bus ();

    shake_block_assembler #(.RATE(RATE), .W(W), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [W-1:0] make_word(input int i);
        return {16'hDEAD, 16'(i), 32'h1234_5678 ^ 32'(i)};
    endfunction

    function automatic logic [W-1:0] word_of(input logic [RATE-1:0] b, input int j);
        logic [RATE-1:0] s;
        s = b << (W * j);
        return s[RATE-1 -: W];
    endfunction

    // Used only to point a failure message at the first differing word.
    function automatic int first_diff(input logic [RATE-1:0] a, input logic [RATE-1:0] e);
        for (int j = 0; j < WORDS; j++) begin
            if (word_of(a, j) !== word_of(e, j)) return j;
        end
        return 0;
    endfunction

    // Called on a falling edge; returns on the falling edge after the word is taken.
    task automatic send_word(input logic [W-1:0] d, input logic last, input logic [6:0] bits);
        int waited;
        waited      = 0;
        bus.s_data  = d;
        bus.s_last  = last;
        bus.s_bits  = bits;
        bus.s_valid = 1'b1;
        while (bus.s_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (bus.s_ready !== 1'b1) begin
            n_checks++;
            $display("[TB] FAIL send_timeout: s_ready=%b after %0d cycles, want 1", bus.s_ready, waited);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_block(output bit ok);
        int waited;
        waited = 0;
        while (bus.blk_valid !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        ok = (bus.blk_valid === 1'b1);
        if (!ok) begin
            n_checks++;
            $display("[TB] FAIL block_timeout: blk_valid=%b after %0d cycles, want 1", bus.blk_valid, waited);
        end
    endtask

    task automatic take_block();
        bus.blk_ready = 1'b1;
        @(negedge clk);
        bus.blk_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.s_bits = '0; bus.blk_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.s_ready !== 1'b0) $display("[TB] FAIL reset_s_ready: got %b want 0", bus.s_ready); else n_pass++;
        n_checks++; if (bus.blk_valid !== 1'b0) $display("[TB] FAIL reset_blk_valid: got %b want 0", bus.blk_valid); else n_pass++;
        n_checks++; if (bus.blk_len !== 11'd0) $display("[TB] FAIL reset_blk_len: got %0d want 0", bus.blk_len); else n_pass++;
        n_checks++; if (bus.blk_last !== 1'b0) $display("[TB] FAIL reset_blk_last: got %b want 0", bus.blk_last); else n_pass++;
        n_checks++;
        if (bus.blk_data !== '0)
            $display("[TB] FAIL reset_blk_data: word %0d = %h want 0", first_diff(bus.blk_data, '0), word_of(bus.blk_data, first_diff(bus.blk_data, '0)));
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.s_ready !== 1'b1) $display("[TB] FAIL post_reset_s_ready: got %b want 1", bus.s_ready); else n_pass++;
    endtask

    task automatic test_empty();
        bus.blk_ready = 1'b1;
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 7'd0);
        n_checks++; if (bus.s_ready !== 1'b0) $display("[TB] FAIL empty_bubble: s_ready got %b want 0", bus.s_ready); else n_pass++;
        n_checks++; if (bus.blk_valid !== 1'b1) $display("[TB] FAIL empty_valid: got %b want 1", bus.blk_valid); else n_pass++;
        n_checks++; if (bus.blk_len !== 11'd0) $display("[TB] FAIL empty_len: got %0d want 0", bus.blk_len); else n_pass++;
        n_checks++; if (bus.blk_last !== 1'b1) $display("[TB] FAIL empty_last: got %b want 1", bus.blk_last); else n_pass++;
        n_checks++;
        if (bus.blk_data !== '0)
            $display("[TB] FAIL empty_data: word %0d = %h want 0", first_diff(bus.blk_data, '0), word_of(bus.blk_data, first_diff(bus.blk_data, '0)));
        else n_pass++;
        @(negedge clk);
        bus.blk_ready = 1'b0;
        n_checks++; if (bus.s_ready !== 1'b1) $display("[TB] FAIL empty_ready_back: got %b want 1", bus.s_ready); else n_pass++;
        n_checks++; if (bus.blk_valid !== 1'b0) $display("[TB] FAIL empty_valid_drop: got %b want 0", bus.blk_valid); else n_pass++;
    endtask

    task automatic test_short();
        logic [RATE-1:0] exp;
        bit ok;
        int d;
        exp = '0;
        exp[RATE-1 -: 24] = 24'h012345;
        send_word(64'h0123_4567_89AB_CDEF, 1'b1, 7'd24);
        wait_block(ok);
        if (ok) begin
            n_checks++; if (bus.blk_len !== 11'd24) $display("[TB] FAIL short_len: got %0d want 24", bus.blk_len); else n_pass++;
            n_checks++; if (bus.blk_last !== 1'b1) $display("[TB] FAIL short_last: got %b want 1", bus.blk_last); else n_pass++;
            d = first_diff(bus.blk_data, exp);
            n_checks++;
            if (bus.blk_data !== exp) $display("[TB] FAIL short_data: word %0d = %h want %h", d, word_of(bus.blk_data, d), word_of(exp, d));
            else n_pass++;
        end
        take_block();
    endtask

    task automatic test_exact_rate();
        logic [RATE-1:0] exp;
        bit ok;
        int d;
        exp = '0;
        for (int i = 0; i < WORDS; i++) begin
            exp = {exp[RATE-W-1:0], make_word(i)};
            send_word(make_word(i), (i == WORDS - 1), (i == WORDS - 1) ? 7'd64 : 7'd3);
        end
        wait_block(ok);
        if (ok) begin
            n_checks++; if (bus.blk_len !== 11'd1088) $display("[TB] FAIL exact_len: got %0d want 1088", bus.blk_len); else n_pass++;
            n_checks++; if (bus.blk_last !== 1'b1) $display("[TB] FAIL exact_last: got %b want 1", bus.blk_last); else n_pass++;
            n_checks++;
            if (bus.blk_data[W-1:0] !== make_word(16)) $display("[TB] FAIL exact_word16: got %h want %h", bus.blk_data[W-1:0], make_word(16));
            else n_pass++;
            d = first_diff(bus.blk_data, exp);
            n_checks++;
            if (bus.blk_data !== exp) $display("[TB] FAIL exact_data: word %0d = %h want %h", d, word_of(bus.blk_data, d), word_of(exp, d));
            else n_pass++;
        end
        take_block();
    endtask

    // 21 words: a full block, then three full words plus an 8-bit tail (3*64+8 = 200).
    task automatic test_two_block();
        logic [RATE-1:0] exp1;
        logic [RATE-1:0] exp2;
        logic [W-1:0]    w;
        bit ok;
        int d;
        exp1 = '0;
        for (int i = 0; i < WORDS; i++) begin
            exp1 = {exp1[RATE-W-1:0], make_word(i)};
            send_word(make_word(i), 1'b0, 7'd5);
        end
        wait_block(ok);
        if (ok) begin
            n_checks++; if (bus.blk_len !== 11'd1088) $display("[TB] FAIL two_b1_len: got %0d want 1088", bus.blk_len); else n_pass++;
            n_checks++; if (bus.blk_last !== 1'b0) $display("[TB] FAIL two_b1_last: got %b want 0", bus.blk_last); else n_pass++;
            d = first_diff(bus.blk_data, exp1);
            n_checks++;
            if (bus.blk_data !== exp1) $display("[TB] FAIL two_b1_data: word %0d = %h want %h", d, word_of(bus.blk_data, d), word_of(exp1, d));
            else n_pass++;
        end
        take_block();
        exp2 = '0;
        for (int j = 0; j < WORDS; j++) begin
            w = '0;
            if (j < 3) w = make_word(17 + j);
            if (j == 3) w = make_word(20) & {8'hFF, 56'h0};
            exp2 = {exp2[RATE-W-1:0], w};
        end
        for (int i = 17; i <= 20; i++) begin
            send_word(make_word(i), (i == 20), (i == 20) ? 7'd8 : 7'd0);
        end
        wait_block(ok);
        if (ok) begin
            n_checks++; if (bus.blk_len !== 11'd200) $display("[TB] FAIL two_b2_len: got %0d want 200", bus.blk_len); else n_pass++;
            n_checks++; if (bus.blk_last !== 1'b1) $display("[TB] FAIL two_b2_last: got %b want 1", bus.blk_last); else n_pass++;
            n_checks++;
            if (bus.blk_data[RATE-1 -: W] !== make_word(17)) $display("[TB] FAIL two_b2_first: got %h want %h", bus.blk_data[RATE-1 -: W], make_word(17));
            else n_pass++;
            d = first_diff(bus.blk_data, exp2);
            n_checks++;
            if (bus.blk_data !== exp2) $display("[TB] FAIL two_b2_data: word %0d = %h want %h", d, word_of(bus.blk_data, d), word_of(exp2, d));
            else n_pass++;
        end
        take_block();
    endtask

    task automatic test_backpressure();
        logic [RATE-1:0] exp_a;
        logic [RATE-1:0] exp_b;
        int d;
        exp_a = '0;
        exp_a[RATE-1 -: W] = 64'hFEDC_BA98_7654_3210;
        exp_b = '0;
        exp_b[RATE-1 -: 16] = 16'h1357;
        send_word(64'hFEDC_BA98_7654_3210, 1'b1, 7'd64);
        bus.s_data  = 64'h1357_9BDF_2468_ACE0;
        bus.s_last  = 1'b1;
        bus.s_bits  = 7'd16;
        bus.s_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (bus.s_ready !== 1'b0) $display("[TB] FAIL bp_s_ready c%0d: got %b want 0", c, bus.s_ready); else n_pass++;
            n_checks++; if (bus.blk_valid !== 1'b1) $display("[TB] FAIL bp_valid c%0d: got %b want 1", c, bus.blk_valid); else n_pass++;
            n_checks++; if (bus.blk_len !== 11'd64) $display("[TB] FAIL bp_len c%0d: got %0d want 64", c, bus.blk_len); else n_pass++;
            d = first_diff(bus.blk_data, exp_a);
            n_checks++;
            if (bus.blk_data !== exp_a) $display("[TB] FAIL bp_data c%0d: word %0d = %h want %h", c, d, word_of(bus.blk_data, d), word_of(exp_a, d));
            else n_pass++;
            @(negedge clk);
        end
        take_block();
        n_checks++; if (bus.s_ready !== 1'b1) $display("[TB] FAIL bp_release_ready: got %b want 1", bus.s_ready); else n_pass++;
        n_checks++; if (bus.blk_valid !== 1'b0) $display("[TB] FAIL bp_release_valid: got %b want 0", bus.blk_valid); else n_pass++;
        @(negedge clk);
        bus.s_valid = 1'b0;
        n_checks++; if (bus.blk_valid !== 1'b1) $display("[TB] FAIL bp_next_valid: got %b want 1", bus.blk_valid); else n_pass++;
        n_checks++; if (bus.blk_len !== 11'd16) $display("[TB] FAIL bp_next_len: got %0d want 16", bus.blk_len); else n_pass++;
        d = first_diff(bus.blk_data, exp_b);
        n_checks++;
        if (bus.blk_data !== exp_b) $display("[TB] FAIL bp_next_data: word %0d = %h want %h", d, word_of(bus.blk_data, d), word_of(exp_b, d));
        else n_pass++;
        take_block();
    endtask

    task automatic test_reset_mid_fill();
        logic [RATE-1:0] exp;
        bit ok;
        int d;
        exp = '0;
        exp[RATE-1 -: 8] = 8'hC3;
        for (int i = 0; i < 5; i++) send_word(make_word(100 + i), 1'b0, 7'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.s_ready !== 1'b1) $display("[TB] FAIL rmf_s_ready: got %b want 1", bus.s_ready); else n_pass++;
        n_checks++; if (bus.blk_valid !== 1'b0) $display("[TB] FAIL rmf_valid: got %b want 0", bus.blk_valid); else n_pass++;
        send_word(64'hC3A5_5A3C_0F0F_F0F0, 1'b1, 7'd8);
        wait_block(ok);
        if (ok) begin
            n_checks++; if (bus.blk_len !== 11'd8) $display("[TB] FAIL rmf_len: got %0d want 8", bus.blk_len); else n_pass++;
            n_checks++; if (bus.blk_last !== 1'b1) $display("[TB] FAIL rmf_last: got %b want 1", bus.blk_last); else n_pass++;
            d = first_diff(bus.blk_data, exp);
            n_checks++;
            if (bus.blk_data !== exp) $display("[TB] FAIL rmf_data: word %0d = %h want %h", d, word_of(bus.blk_data, d), word_of(exp, d));
            else n_pass++;
        end
        take_block();
    endtask

    task automatic test_clamp();
        logic [RATE-1:0] exp;
        bit ok;
        int d;
        exp = '0;
        exp[RATE-1 -: W] = 64'hA1B2_C3D4_E5F6_0718;
        send_word(64'hA1B2_C3D4_E5F6_0718, 1'b1, 7'd100);
        wait_block(ok);
        if (ok) begin
            n_checks++; if (bus.blk_len !== 11'd64) $display("[TB] FAIL clamp_len: got %0d want 64", bus.blk_len); else n_pass++;
            d = first_diff(bus.blk_data, exp);
            n_checks++;
            if (bus.blk_data !== exp) $display("[TB] FAIL clamp_data: word %0d = %h want %h", d, word_of(bus.blk_data, d), word_of(exp, d));
            else n_pass++;
        end
        take_block();
    endtask

    initial begin
        test_reset();
        test_empty();
        test_short();
        test_exact_rate();
        test_two_block();
        test_backpressure();
        test_reset_mid_fill();
        test_clamp();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d checks done", n_pass, n_checks);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
